axi_rd_arbiter: RTL

//  2-to-1 AXI3 read-channel arbiter: lets two AXI masters (e.g. two bfm_axi instances) share one downstream read port.

---
 rtl/axi_rd_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// 2-to-1 AXI3 read-channel arbiter: one outstanding burst, AR muxed from the granted master, R routed back.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (M0 wins); default build is round-robin.
module axi_rd_arbiter #(
   parameter int WIDTH_ID = 4,
   parameter int WIDTH_AD = 32,
   parameter int WIDTH_DA = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [WIDTH_ID-1:0] M0_ARID,
   input  logic [WIDTH_AD-1:0] M0_ARADDR,
   input  logic [3:0]          M0_ARLEN,
   input  logic [2:0]          M0_ARSIZE,
   input  logic [1:0]          M0_ARBURST,
   input  logic                M0_ARVALID,
   output logic                M0_ARREADY,
   output logic [WIDTH_ID-1:0] M0_RID,
   output logic [WIDTH_DA-1:0] M0_RDATA,
   output logic [1:0]          M0_RRESP,
   output logic                M0_RLAST,
   output logic                M0_RVALID,
   input  logic                M0_RREADY,
   input  logic [WIDTH_ID-1:0] M1_ARID,
   input  logic [WIDTH_AD-1:0] M1_ARADDR,
   input  logic [3:0]          M1_ARLEN,
   input  logic [2:0]          M1_ARSIZE,
   input  logic [1:0]          M1_ARBURST,
   input  logic                M1_ARVALID,
   output logic                M1_ARREADY,
   output logic [WIDTH_ID-1:0] M1_RID,
   output logic [WIDTH_DA-1:0] M1_RDATA,
   output logic [1:0]          M1_RRESP,
   output logic                M1_RLAST,
   output logic                M1_RVALID,
   input  logic                M1_RREADY,
   output logic [WIDTH_ID:0]   S_ARID,
   output logic [WIDTH_AD-1:0] S_ARADDR,
   output logic [3:0]          S_ARLEN,
   output logic [2:0]          S_ARSIZE,
   output logic [1:0]          S_ARBURST,
   output logic                S_ARVALID,
   input  logic                S_ARREADY,
   input  logic [WIDTH_ID:0]   S_RID,
   input  logic [WIDTH_DA-1:0] S_RDATA,
   input  logic [1:0]          S_RRESP,
   input  logic                S_RLAST,
   input  logic                S_RVALID,
   output logic                S_RREADY,
   output logic                ERR
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  len_q, len_d;
   logic        err_q, err_d;

   logic [WIDTH_ID-1:0] mg_arid;
   logic [WIDTH_AD-1:0] mg_araddr;
   logic [3:0]          mg_arlen;
   logic [2:0]          mg_arsize;
   logic [1:0]          mg_arburst;
   logic                mg_arvalid;
   logic                mg_rready;
   logic                pick;
   logic                beat;
   logic                run;

   always_comb begin
      mg_arid    = grant_q ? M1_ARID    : M0_ARID;
      mg_araddr  = grant_q ? M1_ARADDR  : M0_ARADDR;
      mg_arlen   = grant_q ? M1_ARLEN   : M0_ARLEN;
      mg_arsize  = grant_q ? M1_ARSIZE  : M0_ARSIZE;
      mg_arburst = grant_q ? M1_ARBURST : M0_ARBURST;
      mg_arvalid = grant_q ? M1_ARVALID : M0_ARVALID;
      mg_rready  = grant_q ? M1_RREADY  : M0_RREADY;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      pick = ~M0_ARVALID;
`else
      pick = (M0_ARVALID & M1_ARVALID) ? ~last_q : M1_ARVALID;
`endif
      beat = (state_q == DATA) & S_RVALID & mg_rready;
      // Reset gates every handshake output so nothing is forwarded in the reset cycle itself.
      run  = ~ARESET;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (M0_ARVALID | M1_ARVALID) begin
               grant_d = pick;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (mg_arvalid & S_ARREADY) begin
               len_d   = mg_arlen;
               cnt_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               cnt_d = cnt_q + 4'd1;
               if (S_RLAST) begin
                  last_d  = grant_q;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (beat && ((S_RID[WIDTH_ID] != grant_q) || (S_RLAST != (cnt_q == len_q))))
         err_d = 1'b1;
      if (S_RVALID && (state_q != DATA))
         err_d = 1'b1;
   end

   always_comb begin
      S_ARID     = '0;
      S_ARADDR   = '0;
      S_ARLEN    = '0;
      S_ARSIZE   = '0;
      S_ARBURST  = '0;
      S_ARVALID  = 1'b0;
      S_RREADY   = 1'b0;
      M0_ARREADY = 1'b0;
      M1_ARREADY = 1'b0;
      M0_RID     = '0;
      M0_RDATA   = '0;
      M0_RRESP   = '0;
      M0_RLAST   = 1'b0;
      M0_RVALID  = 1'b0;
      M1_RID     = '0;
      M1_RDATA   = '0;
      M1_RRESP   = '0;
      M1_RLAST   = 1'b0;
      M1_RVALID  = 1'b0;
      case (state_q)
         ADDR: begin
            S_ARID    = {grant_q, mg_arid};
            S_ARADDR  = mg_araddr;
            S_ARLEN   = mg_arlen;
            S_ARSIZE  = mg_arsize;
            S_ARBURST = mg_arburst;
            S_ARVALID = mg_arvalid & run;
            if (grant_q) M1_ARREADY = S_ARREADY & run;
            else         M0_ARREADY = S_ARREADY & run;
         end
         DATA: begin
            S_RREADY = mg_rready & run;
            if (grant_q) begin
               M1_RID    = S_RID[WIDTH_ID-1:0];
               M1_RDATA  = S_RDATA;
               M1_RRESP  = S_RRESP;
               M1_RLAST  = S_RLAST;
               M1_RVALID = S_RVALID & run;
            end else begin
               M0_RID    = S_RID[WIDTH_ID-1:0];
               M0_RDATA  = S_RDATA;
               M0_RRESP  = S_RRESP;
               M0_RLAST  = S_RLAST;
               M0_RVALID = S_RVALID & run;
            end
         end
         default: ;
      endcase
      ERR = err_q;
   end

endmodule
